uart_tx_frame: RTL and testbench

Serial UART transmitter for the UART block: accepts a parallel byte with a single-cycle valid strobe and sends one asynchronous frame on TX_OUT. The frame is a start bit, 8 data bits LSB first, an optional parity bit and one stop bit. It is the transmit counterpart of the UART RX path. Parity polarity matches the RX parity checker: even parity is ^data and odd parity is ~^data. The block sits between the system-side register/FIFO logic and the TX pad.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_parity_calc.sv | 19 +
 rtl/uart_tx_frame.sv | 154 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic        PAR_EVEN           = 1'b0;
    localparam logic        PAR_ODD            = 1'b1;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam logic        IDLE_LEVEL         = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of the latched transmit byte; polarity matches the RX checker.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    always_comb begin
        parity = ^data;
        if (par_typ == PAR_ODD) begin
            parity = ~^data;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, one stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   DATA_VALID,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    output logic                   TX_OUT,
    output logic                   BUSY
);

    localparam int unsigned IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

    tx_state_e              state_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] cnt_q;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [IDX_WIDTH-1:0]   idx_nxt;
    logic                   bit_done;

    assign idx_nxt  = idx_q + IDX_WIDTH'(1);
    assign bit_done = (cnt_q == presc_q - PRESC_WIDTH'(1));

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic parity_bit;

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data   (data_q),
        .par_typ(par_typ_q),
        .parity (parity_bit)
    );
`else
    logic unused_par_inputs;
    assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

    // Outputs are loaded with the value of the state being entered, so they are pure flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            data_q    <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            TX_OUT    <= IDLE_LEVEL;
            BUSY      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    TX_OUT <= IDLE_LEVEL;
                    BUSY   <= 1'b0;
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        presc_q   <= (PRESCALE == '0) ? PRESC_WIDTH'(1) : PRESCALE;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
`endif
                        state_q   <= StStart;
                        TX_OUT    <= 1'b0;
                        BUSY      <= 1'b1;
                    end
                end

                StStart: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= StData;
                        TX_OUT  <= data_q[0];
                    end else begin
                        cnt_q <= cnt_q + PRESC_WIDTH'(1);
                    end
                end

                StData: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_q <= StParity;
                                TX_OUT  <= parity_bit;
                            end else begin
                                state_q <= StStop;
                                TX_OUT  <= IDLE_LEVEL;
                            end
`else
                            state_q <= StStop;
                            TX_OUT  <= IDLE_LEVEL;
`endif
                        end else begin
                            idx_q  <= idx_nxt;
                            TX_OUT <= data_q[idx_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + PRESC_WIDTH'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        state_q <= StStop;
                        TX_OUT  <= IDLE_LEVEL;
                    end else begin
                        cnt_q <= cnt_q + PRESC_WIDTH'(1);
                    end
                end
`endif

                StStop: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        TX_OUT  <= IDLE_LEVEL;
                        BUSY    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + PRESC_WIDTH'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    TX_OUT  <= IDLE_LEVEL;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame; expected frames are rebuilt from the stimulus.
module tb_uart_tx_frame;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic [5:0] presc;
    } frame_t;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       BUSY;

    frame_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    uart_tx_frame dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .PRESCALE  (PRESCALE),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        frame_t f;
        @(posedge CLK);
        #1;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        PRESCALE   = ps;
        DATA_VALID = 1'b1;
        f.data = d; f.par_en = pe; f.par_typ = pt; f.presc = ps;
        sb.push_back(f);
        @(posedge CLK);
        #1;
        DATA_VALID = 1'b0;
    endtask

    // Waits for BUSY, pops the expected frame and checks every cycle of it.
    task automatic check_frame(output int gap);
        frame_t      e;
        logic [10:0] bits;
        int          nbits;
        int          p;
        logic        pa;
        gap = 0;
        @(negedge CLK);
        while (!BUSY && gap < 200) begin
            @(negedge CLK);
            gap++;
        end
        if (!BUSY) begin
            check_eq("busy_timeout", 32'(BUSY), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check_eq("unexpected_frame", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
`ifdef UART_TX_PARITY_EN
        pa = e.par_en;
`else
        pa = 1'b0;
`endif
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = e.data;
        if (pa) begin
            bits[9] = e.par_typ ? ~^e.data : ^e.data;
            nbits   = 11;
        end else begin
            nbits   = 10;
        end
        p = (e.presc == 0) ? 1 : int'(e.presc);
        for (int c = 0; c < nbits * p; c++) begin
            check_eq("tx_bit", 32'(TX_OUT), 32'(bits[c / p]));
            check_eq("busy_in_frame", 32'(BUSY), 32'd1);
            @(negedge CLK);
        end
        check_eq("busy_after_frame", 32'(BUSY), 32'd0);
        check_eq("tx_after_frame", 32'(TX_OUT), 32'd1);
    endtask

    initial begin
        int g1;
        int g2;
        int seen;
        int w;
        RST        = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        PRESCALE   = '0;
        repeat (3) @(negedge CLK);
        check_eq("reset_tx", 32'(TX_OUT), 32'd1);
        check_eq("reset_busy", 32'(BUSY), 32'd0);
        RST = 1'b1;

        fork send(8'hA5, 1'b1, 1'b0, 6'd1); check_frame(g1); join
        fork send(8'hA5, 1'b1, 1'b1, 6'd1); check_frame(g1); join
        fork send(8'h00, 1'b0, 1'b0, 6'd4); check_frame(g1); join
        fork send(8'hC3, 1'b1, 1'b0, 6'd0); check_frame(g1); join
        fork send(8'h01, 1'b1, 1'b0, 6'd1); check_frame(g1); join

        // Request and input changes while busy must not disturb or queue anything.
        fork
            begin
                send(8'h3C, 1'b1, 1'b1, 6'd2);
                repeat (4) @(posedge CLK);
                #1;
                P_DATA     = 8'hFF;
                DATA_VALID = 1'b1;
                @(posedge CLK);
                #1;
                DATA_VALID = 1'b0;
                P_DATA     = 8'h00;
                PRESCALE   = 6'd7;
                PAR_TYP    = 1'b0;
                PAR_EN     = 1'b0;
            end
            check_frame(g1);
        join
        seen = 0;
        repeat (30) begin
            @(negedge CLK);
            if (BUSY) seen++;
        end
        check_eq("no_extra_frame", 32'(seen), 32'd0);

        // Asynchronous reset in data bit 3 of 0x96 (bit value 0).
        send(8'h96, 1'b0, 1'b0, 6'd3);
        repeat (12) @(posedge CLK);
        #1;
        check_eq("pre_reset_tx", 32'(TX_OUT), 32'd0);
        check_eq("pre_reset_busy", 32'(BUSY), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check_eq("abort_tx", 32'(TX_OUT), 32'd1);
        check_eq("abort_busy", 32'(BUSY), 32'd0);
        sb.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("post_reset_busy", 32'(BUSY), 32'd0);

        // DATA_VALID held high across two frames.
        fork
            begin
                frame_t f;
                @(posedge CLK);
                #1;
                P_DATA     = 8'h55;
                PAR_EN     = 1'b0;
                PAR_TYP    = 1'b0;
                PRESCALE   = 6'd1;
                DATA_VALID = 1'b1;
                f.data = 8'h55; f.par_en = 1'b0; f.par_typ = 1'b0; f.presc = 6'd1;
                sb.push_back(f);
                @(posedge CLK);
                #1;
                P_DATA = 8'h0F;
                f.data = 8'h0F;
                sb.push_back(f);
                w = 0;
                while (BUSY && w < 100) begin
                    @(posedge CLK);
                    #1;
                    w++;
                end
                @(posedge CLK);
                #1;
                DATA_VALID = 1'b0;
            end
            begin
                check_frame(g1);
                check_frame(g2);
                check_eq("b2b_idle_cycles", 32'(g2 + 1), 32'd1);
            end
        join

        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
